// File: rtl/lsync_peak_detector.sv
// lsync_peak_detector
// Long-sync peak pair search behind the long-preamble correlator. It forms the
// squared correlation magnitude and looks for two peaks PEAK_SPACING samples
// apart (peak 2 within +/-GUARD). On a confirmed pair it raises locked. It then
// counts DATA_OFFSET samples from peak 2 and marks the first data sample with
// sync_done. data_gate opens on that marker and feeds the CP-removal/FFT stage.
//
// Sample qualification: corr_strobe is a valid-only strobe (there is no ready).
// A cycle with corr_strobe=1 carries exactly one correlator sample. Only such
// cycles advance the FSM and the sample counters. Cycles without a strobe hold
// all state and force sync_done low.
//
// fsm_state exposes the FSM state for debug: 0 IDLE, 1 HUNT, 2 TRACK1,
// 3 WAIT2, 4 ALIGN, 5 DONE.
module lsync_peak_detector #(
   parameter int THRESH       = 200,
   parameter int PEAK_SPACING = 64,
   parameter int GUARD        = 2,
   parameter int DATA_OFFSET  = 49
) (
   input  logic        CLK,
   input  logic        s_RST,
   input  logic        enable,
   input  logic        corr_strobe,
   input  logic [5:0]  I_corr_In,
   input  logic [5:0]  Q_corr_In,
   output logic        locked,
   output logic        sync_done,
   output logic        data_gate,
   output logic [11:0] peak1_mag,
   output logic [11:0] peak2_mag,
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HUNT   = 3'd1,
      TRACK1 = 3'd2,
      WAIT2  = 3'd3,
      ALIGN  = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [11:0] THR        = 12'(THRESH);
   // Peak 1 is final once this many further samples pass without a larger one;
   // the next sample is then the first sample of the peak-2 window.
   localparam logic [7:0]  SINCE1_END = 8'(PEAK_SPACING - GUARD - 1);
   localparam logic [7:0]  WIN_LAST   = 8'(2 * GUARD);
   localparam logic [7:0]  OFFSET     = 8'(DATA_OFFSET);

   state_t      state, state_nx;

   logic [11:0] best1, best2;
   logic [7:0]  since1, since2, win;

   logic [11:0] i_ext, q_ext, i_sq, q_sq, mag;
   logic [7:0]  since1_inc, since2_inc, win_inc;
   logic        new_max1, new_max2;
   logic [11:0] best2_upd;
   logic        pair_ok;
   logic        strobe_en;

   logic        ev_p1_start, ev_p1_update, ev_p1_age, ev_open;
   logic        ev_win, ev_close, ev_lock, ev_align, ev_sync;

   // Squares are taken modulo 2^12 on sign-extended operands. The low 12 bits
   // of a two's-complement product are exact. |x|<=32 keeps each square <=1024
   // and the sum <=2048, so nothing wraps.
   assign i_ext = {{6{I_corr_In[5]}}, I_corr_In};
   assign q_ext = {{6{Q_corr_In[5]}}, Q_corr_In};
   assign i_sq  = i_ext * i_ext;
   assign q_sq  = q_ext * q_ext;
   assign mag   = i_sq + q_sq;

   assign since1_inc = since1 + 8'd1;
   assign since2_inc = since2 + 8'd1;
   assign win_inc    = win + 8'd1;
   assign new_max1   = (mag > best1);
   assign new_max2   = (mag > best2);
   // A candidate on the last window sample counts toward the pair decision.
   assign best2_upd  = new_max2 ? mag : best2;
   assign pair_ok    = (best2_upd >= THR);
   assign strobe_en  = enable && corr_strobe;

   assign fsm_state  = state;

   // State register.
   always_ff @(posedge CLK) begin
      if (s_RST) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; enable low wins over any strobe.
   always_comb begin
      state_nx = state;
      if (!enable) begin
         state_nx = IDLE;
      end else if (corr_strobe) begin
         case (state)
            IDLE:    state_nx = HUNT;
            HUNT:    if (mag >= THR) state_nx = TRACK1;
            TRACK1:  if (ev_open) state_nx = WAIT2;
            WAIT2:   if (ev_close) state_nx = pair_ok ? ALIGN : HUNT;
            ALIGN:   if (ev_sync) state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Per-sample events decoded from the current state; they steer the datapath.
   always_comb begin
      ev_p1_start  = 1'b0;
      ev_p1_update = 1'b0;
      ev_p1_age    = 1'b0;
      ev_open      = 1'b0;
      ev_win       = 1'b0;
      ev_close     = 1'b0;
      ev_lock      = 1'b0;
      ev_align     = 1'b0;
      ev_sync      = 1'b0;
      if (strobe_en) begin
         case (state)
            HUNT: begin
               ev_p1_start = (mag >= THR);
            end
            TRACK1: begin
               ev_p1_update = new_max1;
               ev_p1_age    = !new_max1;
               ev_open      = !new_max1 && (since1_inc == SINCE1_END);
            end
            WAIT2: begin
               ev_win   = 1'b1;
               ev_close = (win == WIN_LAST);
               ev_lock  = (win == WIN_LAST) && pair_ok;
            end
            ALIGN: begin
               ev_align = 1'b1;
               ev_sync  = (since2_inc == OFFSET);
            end
            default: begin
            end
         endcase
      end
   end

   // Peak tracking, sample counters and registered outputs.
   always_ff @(posedge CLK) begin
      if (s_RST) begin
         best1     <= '0;
         best2     <= '0;
         since1    <= '0;
         since2    <= '0;
         win       <= '0;
         locked    <= 1'b0;
         sync_done <= 1'b0;
         data_gate <= 1'b0;
         peak1_mag <= '0;
         peak2_mag <= '0;
      end else if (!enable) begin
         // Partial search data is dropped; the last reported peaks are kept.
         best1     <= '0;
         best2     <= '0;
         since1    <= '0;
         since2    <= '0;
         win       <= '0;
         locked    <= 1'b0;
         sync_done <= 1'b0;
         data_gate <= 1'b0;
      end else begin
         sync_done <= ev_sync;

         if (ev_p1_start || ev_p1_update) begin
            best1  <= mag;
            since1 <= '0;
         end else if (ev_p1_age) begin
            since1 <= since1_inc;
         end

         if (ev_open) begin
            win    <= '0;
            best2  <= '0;
            since2 <= '0;
         end else if (ev_win) begin
            win    <= win_inc;
            best2  <= best2_upd;
            since2 <= new_max2 ? 8'd0 : since2_inc;
         end else if (ev_align) begin
            since2 <= since2_inc;
         end

         if (ev_lock) begin
            locked    <= 1'b1;
            peak1_mag <= best1;
            peak2_mag <= best2_upd;
         end

         if (ev_sync) begin
            data_gate <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lsync_peak_detector.sv
// Bench for lsync_peak_detector. The reference model scans the whole sample
// sequence with the peak-pair rules. It predicts the lock sample, the
// sync_done sample and both peak magnitudes. Every output is then checked
// after every cycle.
module tb_lsync_peak_detector;

   localparam int THRESH = 200;
   localparam int SP     = 64;
   localparam int GUARD  = 2;
   localparam int OFF    = 49;
   localparam int T1_END = SP - GUARD - 1;
   localparam int WIN    = 2 * GUARD + 1;
   localparam int MAXN   = 256;

   logic        CLK = 1'b0;
   logic        s_RST;
   logic        enable;
   logic        corr_strobe;
   logic [5:0]  I_corr_In;
   logic [5:0]  Q_corr_In;
   logic        locked;
   logic        sync_done;
   logic        data_gate;
   logic [11:0] peak1_mag;
   logic [11:0] peak2_mag;
   logic [2:0]  fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic signed [5:0] si [MAXN];
   logic signed [5:0] sq [MAXN];
   int                m  [MAXN];
   int                e_lock, e_sync, e_p1, e_p2;
   logic [15:0]       exp_q [$];

   lsync_peak_detector #(
      .THRESH(THRESH), .PEAK_SPACING(SP), .GUARD(GUARD), .DATA_OFFSET(OFF)
   ) dut (
      .CLK(CLK), .s_RST(s_RST), .enable(enable), .corr_strobe(corr_strobe),
      .I_corr_In(I_corr_In), .Q_corr_In(Q_corr_In),
      .locked(locked), .sync_done(sync_done), .data_gate(data_gate),
      .peak1_mag(peak1_mag), .peak2_mag(peak2_mag), .fsm_state(fsm_state)
   );

   // Clock.
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // One clock with the given inputs; outputs are sampled 1 time unit later.
   task automatic cycle(input logic stb, input logic [5:0] i, input logic [5:0] q);
      corr_strobe = stb;
      I_corr_In   = i;
      Q_corr_In   = q;
      @(posedge CLK);
      #1;
   endtask

   task automatic put(input int k, input int i, input int q);
      si[k] = 6'(i);
      sq[k] = 6'(q);
   endtask

   task automatic clear_samples();
      for (int k = 0; k < MAXN; k++) put(k, 0, 0);
   endtask

   function automatic int ramp(input int lo, input int hi);
      int v;
      v = $urandom_range(hi, lo);
      return ($urandom_range(1, 0) == 1) ? -v : v;
   endfunction

   // Reference model. Sample 0 only wakes the search; hunting starts at
   // sample 1. A peak-1 candidate is re-anchored by any strictly larger
   // sample. Once T1_END samples pass without one, the next WIN samples form
   // the peak-2 window. The earliest strict maximum in that window is peak 2.
   function automatic void build_model(input int n);
      int pos, p1, j, best2, p2, idx;
      e_lock = -1; e_sync = -1; e_p1 = 0; e_p2 = 0;
      for (int k = 0; k < n; k++)
         m[k] = int'(si[k]) * int'(si[k]) + int'(sq[k]) * int'(sq[k]);
      pos = 1;
      while (pos < n) begin
         if (m[pos] < THRESH) begin
            pos++;
            continue;
         end
         p1 = pos;
         j  = pos;
         forever begin
            j++;
            if (j >= n) return;
            if (m[j] > m[p1]) p1 = j;
            if (j - p1 == T1_END) break;
         end
         best2 = 0;
         p2    = -1;
         for (int w = 0; w < WIN; w++) begin
            idx = j + 1 + w;
            if (idx >= n) return;
            if (m[idx] > best2) begin
               best2 = m[idx];
               p2    = idx;
            end
         end
         if (best2 >= THRESH) begin
            e_lock = j + WIN;
            e_sync = p2 + OFF;
            e_p1   = m[p1];
            e_p2   = best2;
            return;
         end
         pos = j + WIN + 1;
      end
   endfunction

   // k is the index of the last sample consumed; stb says whether this cycle carried it.
   task automatic check_outputs(input int k, input logic stb);
      logic exp_lk, exp_dg, exp_sd;
      exp_lk = (e_lock >= 0) && (k >= e_lock);
      exp_dg = (e_sync >= 0) && (k >= e_sync);
      exp_sd = stb && (e_sync >= 0) && (k == e_sync);
      check("locked",    32'(locked),    32'(exp_lk));
      check("data_gate", 32'(data_gate), 32'(exp_dg));
      check("sync_done", 32'(sync_done), 32'(exp_sd));
      check("peak1_mag", 32'(peak1_mag), exp_lk ? e_p1 : 0);
      check("peak2_mag", 32'(peak2_mag), exp_lk ? e_p2 : 0);
      if (sync_done) begin
         if (exp_q.size() == 0) check("sync_extra", 32'(sync_done), 0);
         else                   check("sync_index", k, 32'(exp_q.pop_front()));
      end
   endtask

   task automatic do_reset();
      s_RST  = 1'b1;
      enable = 1'b0;
      cycle(1'b0, 6'd0, 6'd0);
      cycle(1'b0, 6'd0, 6'd0);
      s_RST  = 1'b0;
      check("rst_state", 32'(fsm_state), 0);
   endtask

   // Plays si/sq[0..n-1]. gap = idle cycles before each strobe (-1: random 0..2).
   // plan_sync: >=0 expected sync sample, -1 none expected, -2 take the model's.
   task automatic run_seq(input int n, input int gap, input int plan_sync);
      int g;
      build_model(n);
      exp_q.delete();
      if (plan_sync >= 0) exp_q.push_back(16'(plan_sync));
      else if (plan_sync == -2 && e_sync >= 0 && e_sync < n) exp_q.push_back(16'(e_sync));
      enable = 1'b1;
      for (int k = 0; k < n; k++) begin
         g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
         for (int c = 0; c < g; c++) begin
            cycle(1'b0, 6'($urandom), 6'($urandom));
            check_outputs(k - 1, 1'b0);
         end
         cycle(1'b1, si[k], sq[k]);
         check_outputs(k, 1'b1);
      end
      check("sync_missing", exp_q.size(), 0);
   endtask

   task automatic clean_pair();
      clear_samples();
      put(10, 20, 0);
      put(74, 20, 0);
   endtask

   // Stimulus and final report.
   initial begin
      int p1, p2, a, b;
      s_RST = 1'b1; enable = 1'b0;
      corr_strobe = 1'b0; I_corr_In = '0; Q_corr_In = '0;

      // Reset with random inputs for 3 cycles.
      for (int c = 0; c < 3; c++) begin
         enable = 1'($urandom);
         cycle(1'($urandom), 6'($urandom), 6'($urandom));
         check("rst_locked", 32'(locked), 0);
         check("rst_sync",   32'(sync_done), 0);
         check("rst_gate",   32'(data_gate), 0);
         check("rst_p1",     32'(peak1_mag), 0);
         check("rst_p2",     32'(peak2_mag), 0);
         check("rst_state",  32'(fsm_state), 0);
      end
      s_RST = 1'b0;

      // Clean pair, every cycle a strobe.
      do_reset(); clean_pair(); run_seq(140, 0, 123);
      // Same pair with a strobe every third cycle.
      do_reset(); clean_pair(); run_seq(140, 2, 123);
      // Peak 2 missing.
      do_reset(); clear_samples(); put(10, 20, 0); run_seq(140, 0, -1);
      // Peak 1 re-anchored by a later larger sample.
      do_reset(); clear_samples(); put(10, 16, 0); put(11, 20, 0); put(75, 20, 0);
      run_seq(140, 0, 124);
      // Equal maxima in the window: the earliest one wins.
      do_reset(); clear_samples(); put(10, 20, 0); put(73, 0, 20); put(75, 20, 0);
      run_seq(140, 0, 122);
      // Full-scale peak 1, peak 2 exactly at threshold on the last window sample.
      do_reset(); clear_samples(); put(10, -32, -32); put(76, 10, 10);
      run_seq(140, 0, 125);
      // Peak 2 on the first window sample.
      do_reset(); clear_samples(); put(10, 20, 0); put(72, 0, -20);
      run_seq(140, 0, 121);
      // Peak 2 one sample beyond the window.
      do_reset(); clear_samples(); put(10, 20, 0); put(77, 20, 0);
      run_seq(140, 0, -1);
      // Peak 2 just below threshold (mag 181).
      do_reset(); clear_samples(); put(10, 20, 0); put(74, 9, 10);
      run_seq(140, 0, -1);

      // Randomized sequences with near-miss spacing and amplitudes.
      for (int r = 0; r < 10; r++) begin
         do_reset();
         clear_samples();
         for (int k = 0; k < 200; k++) put(k, ramp(0, 9), ramp(0, 9));
         p1 = $urandom_range(60, 5);
         a = ramp(8, 31); b = ramp(8, 31);
         put(p1, a, b);
         if ($urandom_range(3, 0) == 0) put(p1 + $urandom_range(20, 1), ramp(10, 31), ramp(10, 31));
         p2 = p1 + SP + $urandom_range(6, 0) - 3;
         a = ramp(8, 31); b = ramp(8, 31);
         put(p2, a, b);
         if ($urandom_range(2, 0) == 0) put(p2 + 1, a, b);
         run_seq(200, -1, -2);
      end

      // enable dropped in WAIT2 (sample 73, inside the 72..76 window).
      do_reset(); clean_pair(); run_seq(74, 0, -1);
      enable = 1'b0;
      cycle(1'b1, 6'd20, 6'd0);
      check("abort_state",  32'(fsm_state), 0);
      check("abort_locked", 32'(locked), 0);
      check("abort_sync",   32'(sync_done), 0);
      check("abort_gate",   32'(data_gate), 0);
      enable = 1'b1;
      for (int k = 0; k < 70; k++) begin
         cycle(1'b1, 6'd0, 6'd0);
         check("abort_after_sync",   32'(sync_done), 0);
         check("abort_after_locked", 32'(locked), 0);
      end

      // Reset while in DONE.
      do_reset(); clean_pair(); run_seq(140, 0, 123);
      s_RST = 1'b1;
      cycle(1'b1, 6'd0, 6'd0);
      s_RST = 1'b0;
      check("done_rst_locked", 32'(locked), 0);
      check("done_rst_gate",   32'(data_gate), 0);
      check("done_rst_p1",     32'(peak1_mag), 0);
      check("done_rst_state",  32'(fsm_state), 0);

      // enable dropped in DONE: lock clears, reported peaks hold.
      do_reset(); clean_pair(); run_seq(140, 0, 123);
      enable = 1'b0;
      cycle(1'b1, 6'd20, 6'd0);
      check("done_dis_locked", 32'(locked), 0);
      check("done_dis_gate",   32'(data_gate), 0);
      check("done_dis_sync",   32'(sync_done), 0);
      check("done_dis_p1",     32'(peak1_mag), 400);
      check("done_dis_p2",     32'(peak2_mag), 400);
      check("done_dis_state",  32'(fsm_state), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsync_peak_detector.md
Name: lsync_peak_detector

Overview:
- Downstream stage of the long-preamble correlator.
- Consumes the per-sample complex correlation (6-bit I/Q plus strobe) and forms the squared magnitude.
- Finds the two long-training-symbol correlation peaks spaced PEAK_SPACING samples apart, declares long-sync lock, and emits a one-sample marker at the first data sample.
- Its output gate feeds the CP-removal/FFT front end.

Parameters:
- THRESH, 200, minimum squared magnitude (unsigned 12-bit) accepted as a peak
- PEAK_SPACING, 64, expected distance in samples between peak 1 and peak 2
- GUARD, 2, +/- tolerance in samples on the peak 2 position
- DATA_OFFSET, 49, samples from the peak 2 sample to the first data sample; must exceed 2*GUARD

Ports:
- CLK  in  1  system clock, all logic on rising edge
- s_RST  in  1  synchronous active-high reset
- enable  in  1  search enable; low forces IDLE
- corr_strobe  in  1  one valid correlator sample this cycle
- I_corr_In  in  6  signed correlation real part
- Q_corr_In  in  6  signed correlation imaginary part
- locked  out  1  level; peak pair confirmed
- sync_done  out  1  one-cycle pulse marking the first data sample
- data_gate  out  1  level; high from the sync_done cycle onward
- peak1_mag  out  12  unsigned magnitude of the accepted peak 1
- peak2_mag  out  12  unsigned magnitude of the accepted peak 2

Behaviour:
- Clock and reset: single clock CLK; reset s_RST is synchronous, active-high.
- Reset value of all outputs and registers: 0; state = IDLE.
- Magnitude is combinational: mag = I*I + Q*Q, 12-bit unsigned, range 0..2048, no saturation required.
- Sample accounting: only cycles with corr_strobe=1 advance counters or state. Non-strobe cycles hold everything; sync_done is forced to 0 on them.
- Outputs are registered and update 1 cycle after the qualifying strobe.
- enable=0: synchronous return to IDLE next cycle; clears locked, data_gate and both counters. peak*_mag hold their values.
- States:
  - IDLE: enable=1 -> HUNT.
  - HUNT: on a strobe with mag>=THRESH, set best1<=mag and since1<=0, then -> TRACK1.
  - TRACK1: on each strobe, since1++.
    - If mag>best1 (strict), set best1<=mag and since1<=0. A later larger sample therefore re-anchors peak 1.
    - When since1 reaches PEAK_SPACING-GUARD-1 with no new max, set win<=0 and best2<=0, then -> WAIT2.
  - WAIT2: each strobe is a window sample; win counts 0..2*GUARD.
    - If mag>best2 (strict; the earliest of equal maxima wins), set best2<=mag and since2<=0. Otherwise since2++.
    - On the strobe where win==2*GUARD:
      - If best2>=THRESH: set locked<=1, peak1_mag<=best1, peak2_mag<=best2, then -> ALIGN.
      - Else -> HUNT, with locked remaining 0.
  - ALIGN: on each strobe, since2++. On the strobe where since2 becomes DATA_OFFSET, pulse sync_done, set data_gate<=1, then -> DONE.
  - DONE: holds locked=1 and data_gate=1 until enable=0 or s_RST.
- Window arithmetic: peak 2 is accepted when it lies in [p1+PEAK_SPACING-GUARD, p1+PEAK_SPACING+GUARD]. sync_done corresponds to sample p2+DATA_OFFSET.
- Counter widths: 8 bits for since1, since2 and win. Counters never wrap because TRACK1 and ALIGN exit before 255.
- Simultaneous events:
  - s_RST has priority over enable.
  - enable=0 has priority over any strobe.
  - A peak-2 candidate on the last window strobe is both tracked and evaluated in the same cycle.
- Reset or enable drop mid-search discards all partial peak data; no sync_done is emitted.

Test Plan:
- Reset: assert s_RST for 3 cycles with random inputs -> all outputs 0 and state IDLE.
- Clean pair: THRESH=200, GUARD=2; I=20,Q=0 (mag 400) at strobes #10 and #74, all other samples 0 -> locked=1 the cycle after strobe #76; sync_done pulses once after strobe #123; peak1_mag=peak2_mag=400; data_gate stays 1.
- Missing peak 2: only strobe #10 is nonzero -> returns to HUNT after strobe #76; locked, sync_done and data_gate remain 0.
- Peak-1 re-anchor: mag 256 at #10, mag 400 at #11, mag 400 at #75 -> peak1_mag=400; sync_done after strobe #124.
- Gapped strobes: repeat the clean-pair case with corr_strobe high every 3rd cycle -> identical sample-indexed results; sync_done lasts exactly 1 cycle.
- Abort: drop enable during WAIT2 -> IDLE next cycle with no sync_done. Separately, s_RST in DONE -> locked=0 and data_gate=0 the next cycle.
